// File: rtl/jk_triple_checker.sv
// Self-check for three parallel JK flip-flop implementations. A JK reference
// model runs from the same stimulus, and each implementation is compared against it.
module jk_triple_checker #(
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             J,
    input  logic             K,
    input  logic             Q_sr,
    input  logic             Q_d,
    input  logic             Q_t,
    output logic             ref_q,
    output logic             mismatch,
    output logic [2:0]       mismatch_vec,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] err_count,
    output logic [CYC_W-1:0] cycle_count,
    output logic [CYC_W-1:0] first_err_cycle,
    output logic [2:0]       first_err_vec,
    output logic [CNT_W-1:0] toggle_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CHECK = 2'b01,
        S_FAIL  = 2'b10
    } state_t;

    state_t     cur_state;
    state_t     next_state;
    logic       ref_next;
    logic       cmp;
    logic       fail;
    logic [2:0] vec;

    always_comb begin
        ref_next = ref_q;
        case ({J, K})
            2'b01:   ref_next = 1'b0;
            2'b10:   ref_next = 1'b1;
            2'b11:   ref_next = ~ref_q;
            default: ref_next = ref_q;
        endcase
    end

    // Both sides of the compare are pre-edge values, i.e. the results of the previous edge.
    assign cmp  = en & ~clr;
    assign vec  = {Q_sr ^ ref_q, Q_d ^ ref_q, Q_t ^ ref_q};
    assign fail = cmp & (|vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        if (clr) begin
            next_state = S_IDLE;
        end else if (fail) begin
            next_state = S_FAIL;
        end else begin
            case (cur_state)
                S_IDLE:  next_state = en ? S_CHECK : S_IDLE;
                S_CHECK: next_state = en ? S_CHECK : S_IDLE;
                S_FAIL:  next_state = S_FAIL;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        state = cur_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q           <= 1'b0;
            mismatch        <= 1'b0;
            mismatch_vec    <= 3'b000;
            err_count       <= '0;
            cycle_count     <= '0;
            first_err_cycle <= '0;
            first_err_vec   <= 3'b000;
            toggle_count    <= '0;
        end else begin
            ref_q <= ref_next;
            if (clr) begin
                mismatch        <= 1'b0;
                mismatch_vec    <= 3'b000;
                err_count       <= '0;
                cycle_count     <= '0;
                first_err_cycle <= '0;
                first_err_vec   <= 3'b000;
                toggle_count    <= '0;
            end else begin
                mismatch     <= fail;
                mismatch_vec <= cmp ? vec : 3'b000;
                if (cmp) begin
                    cycle_count <= cycle_count + CYC_W'(1);
                end
                if (fail && (err_count != '1)) begin
                    err_count <= err_count + CNT_W'(1);
                end
                // err_count only returns to zero on clear/reset, so zero marks "no failure yet".
                if (fail && (err_count == '0)) begin
                    first_err_cycle <= cycle_count;
                    first_err_vec   <= vec;
                end
                if ((ref_next != ref_q) && (toggle_count != '1)) begin
                    toggle_count <= toggle_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
